// File: rtl/mandel_frame_dispatcher_if.sv
// rtl/mandel_frame_dispatcher_if.sv - iterator issue/result and frame-buffer write handshakes
// Master is the dispatcher side; slave is the iterator plus frame buffer.
interface mandel_frame_dispatcher_if #(
  parameter int ADDR_W = 19,
  parameter int ITER_W = 11,
  parameter int C_W    = 27
);
  logic              it_val;
  logic              it_rdy;
  logic [C_W-1:0]    it_c_r;
  logic [C_W-1:0]    it_c_i;
  logic              res_val;
  logic              res_rdy;
  logic [ITER_W-1:0] res_iter;
  logic              wr_en;
  logic              wr_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [ITER_W-1:0] wr_data;

  modport master (
    output it_val, it_c_r, it_c_i, res_rdy, wr_en, wr_addr, wr_data,
    input  it_rdy, res_val, res_iter, wr_rdy
  );

  modport slave (
    input  it_val, it_c_r, it_c_i, res_rdy, wr_en, wr_addr, wr_data,
    output it_rdy, res_val, res_iter, wr_rdy
  );
endinterface

// File: rtl/mandel_frame_dispatcher.sv
// rtl/mandel_frame_dispatcher.sv - raster walker feeding one Mandelbrot iterator and the frame buffer
// One pixel in flight: issue c, wait for its count, write it, then step c in 4.23 fixed point.
module mandel_frame_dispatcher #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int ITER_W = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [26:0]               i_x_start,
  input  logic [26:0]               i_y_start,
  input  logic [26:0]               i_dx,
  input  logic [26:0]               i_dy,
  output logic                      o_busy,
  output logic                      o_done,
  mandel_frame_dispatcher_if.master io_bus
);

  localparam int C_W = 27;
  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t            r_state;
  logic [C_W-1:0]    r_x_start;
  logic [C_W-1:0]    r_dx;
  logic [C_W-1:0]    r_dy;
  logic [C_W-1:0]    r_c_r;
  logic [C_W-1:0]    r_c_i;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [ITER_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;

  logic w_row_end;
  logic w_last_pixel;

  assign w_row_end    = (r_x == X_LAST);
  assign w_last_pixel = w_row_end && (r_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x_start <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_c_r     <= '0;
      r_c_i     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // IDLE is also the done cycle, so a start there chains straight into the next frame.
        S_IDLE: begin
          if (i_start) begin
            r_x_start <= i_x_start;
            r_dx      <= i_dx;
            r_dy      <= i_dy;
            r_c_r     <= i_x_start;
            r_c_i     <= i_y_start;
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (io_bus.it_rdy) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_bus.res_val) begin
            r_data  <= io_bus.res_iter;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (io_bus.wr_rdy) begin
            r_addr <= r_addr + 1'b1;
            // c is stepped incrementally; rows restart from the latched column-0 value.
            if (w_row_end) begin
              r_x   <= '0;
              r_c_r <= r_x_start;
              r_y   <= r_y + 1'b1;
              r_c_i <= r_c_i + r_dy;
            end else begin
              r_x   <= r_x + 1'b1;
              r_c_r <= r_c_r + r_dx;
            end
            if (w_last_pixel) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.it_val  = (r_state == S_ISSUE);
  assign io_bus.res_rdy = (r_state == S_WAIT);
  assign io_bus.wr_en   = (r_state == S_WRITE);
  assign io_bus.it_c_r  = r_c_r;
  assign io_bus.it_c_i  = r_c_i;
  assign io_bus.wr_addr = r_addr;
  assign io_bus.wr_data = r_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_mandel_frame_dispatcher.sv
// tb/tb_mandel_frame_dispatcher.sv - randomized self-checking bench for mandel_frame_dispatcher
// Reference model tracks pixels issued/written per frame; iterator answers x+y after a random latency.
module tb_mandel_frame_dispatcher;

  localparam int H_RES  = 4;
  localparam int V_RES  = 3;
  localparam int ADDR_W = 4;
  localparam int ITER_W = 11;
  localparam int NPIX   = H_RES * V_RES;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [26:0] x_start;
  logic [26:0] y_start;
  logic [26:0] dx;
  logic [26:0] dy;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mandel_frame_dispatcher_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus ();

  mandel_frame_dispatcher #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .ITER_W(ITER_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (start),
    .i_x_start(x_start),
    .i_y_start(y_start),
    .i_dx     (dx),
    .i_dy     (dy),
    .o_busy   (busy),
    .o_done   (done),
    .io_bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          m_busy, m_done, m_iter_busy, m_have_res;
  int          m_iss, m_wr, m_lat, m_res_data;
  logic [26:0] m_xs, m_ys, m_dx, m_dy;
  int          hold_rdy = 0;
  int          wr_stall_pct = 30;
  int          writes_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] pix_cr(input int k);
    logic [26:0] col;
    col = 27'(k % H_RES);
    return m_xs + col * m_dx;
  endfunction

  function automatic logic [26:0] pix_ci(input int k);
    logic [26:0] row;
    row = 27'(k / H_RES);
    return m_ys + row * m_dy;
  endfunction

  // One clock: predict transfers from current signals, advance the model, compare, redrive handshakes.
  task automatic step();
    bit it_x, res_x, wr_x, st_x, rst;
    rst   = reset;
    it_x  = !rst && bus.it_val && bus.it_rdy;
    res_x = !rst && bus.res_val && bus.res_rdy;
    wr_x  = !rst && bus.wr_en && bus.wr_rdy;
    st_x  = !rst && start && !m_busy;
    @(negedge clk);
    if (rst) begin
      m_busy = 0; m_done = 0; m_iter_busy = 0; m_have_res = 0; m_iss = 0; m_wr = 0;
    end else begin
      m_done = 0;
      if (m_iter_busy && m_lat > 0) m_lat--;
      if (it_x) begin
        m_iter_busy = 1;
        m_lat       = int'($urandom_range(0, 3));
        m_res_data  = (m_iss % H_RES) + (m_iss / H_RES);
        m_iss++;
      end
      if (res_x) begin
        m_iter_busy = 0;
        m_have_res  = 1;
      end
      if (wr_x) begin
        m_have_res = 0;
        m_wr++;
        writes_total++;
        if (m_wr == NPIX) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (st_x) begin
        m_busy = 1; m_iss = 0; m_wr = 0;
        m_xs = x_start; m_ys = y_start; m_dx = dx; m_dy = dy;
      end
    end

    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("it_val", 32'(bus.it_val), 32'(m_busy && m_iss == m_wr));
    check_eq("res_rdy", 32'(bus.res_rdy), 32'(m_busy && m_iss > m_wr && !m_have_res));
    check_eq("wr_en", 32'(bus.wr_en), 32'(m_busy && m_have_res));
    if (rst) begin
      check_eq("rst_c_r", 32'(bus.it_c_r), 0);
      check_eq("rst_c_i", 32'(bus.it_c_i), 0);
      check_eq("rst_wr_addr", 32'(bus.wr_addr), 0);
      check_eq("rst_wr_data", 32'(bus.wr_data), 0);
    end
    if (m_busy && m_iss == m_wr) begin
      check_eq("it_c_r", 32'(bus.it_c_r), 32'(pix_cr(m_iss)));
      check_eq("it_c_i", 32'(bus.it_c_i), 32'(pix_ci(m_iss)));
    end
    if (m_busy && m_have_res) begin
      check_eq("wr_addr", 32'(bus.wr_addr), 32'(m_wr));
      check_eq("wr_data", 32'(bus.wr_data), 32'((m_wr % H_RES) + (m_wr / H_RES)));
    end

    if (hold_rdy > 0 && m_busy && m_iss == m_wr) begin
      bus.it_rdy = 1'b0;
      hold_rdy--;
    end else begin
      bus.it_rdy = ($urandom_range(0, 3) != 0);
    end
    bus.res_val  = m_iter_busy && m_lat == 0;
    bus.res_iter = (m_iter_busy && m_lat == 0) ? ITER_W'(m_res_data) : ITER_W'($urandom);
    bus.wr_rdy   = ($urandom_range(0, 99) >= 32'(wr_stall_pct));
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (!m_done && n < 2000) begin
      step();
      n++;
    end
    check_eq(tag, 32'(m_done), 1);
  endtask

  task automatic run_to_pixel(input int k);
    int n = 0;
    while (m_wr < k && n < 2000) begin
      step();
      n++;
    end
    check_eq("reach_pixel", 32'(m_wr), 32'(k));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic rand_params();
    x_start = 27'($urandom);
    y_start = 27'($urandom);
    dx      = 27'($urandom);
    dy      = 27'($urandom);
  endtask

  initial begin
    int snap;
    reset = 1'b1; start = 1'b1;
    x_start = '0; y_start = '0; dx = '0; dy = '0;
    bus.it_rdy = 1'b0; bus.res_val = 1'b0; bus.res_iter = '0; bus.wr_rdy = 1'b0;
    m_busy = 0; m_done = 0; m_iter_busy = 0; m_have_res = 0;
    m_iss = 0; m_wr = 0; m_lat = 0; m_res_data = 0;
    m_xs = '0; m_ys = '0; m_dx = '0; m_dy = '0;
    @(negedge clk);

    // reset held two cycles with start high; start must not take effect
    step();
    step();
    reset = 1'b0; start = 1'b0;
    step();
    step();

    // directed frame with an initial it_rdy hold of 5 ISSUE cycles
    x_start = 27'h7000000; dx = 27'h0400000; y_start = 27'h0800000; dy = 27'h7C00000;
    hold_rdy = 5;
    pulse_start();
    check_eq("first_c_r", 32'(bus.it_c_r), 32'h7000000);
    check_eq("first_c_i", 32'(bus.it_c_i), 32'h0800000);
    run_to_pixel(5);
    check_eq("row1_c_i_model", 32'(pix_ci(4)), 32'h0400000);
    run_to_done("frame_directed");
    step();
    check_eq("busy_after_done", 32'(busy), 0);

    // start pulsed mid-frame with different parameters must be ignored
    rand_params();
    pulse_start();
    run_to_pixel(3);
    rand_params();
    pulse_start();
    run_to_done("frame_mid_start");

    // reset at pixel 6: no further writes, then restart from address 0
    rand_params();
    pulse_start();
    run_to_pixel(6);
    snap = writes_total;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    check_eq("writes_after_reset", 32'(writes_total - snap), 0);
    rand_params();
    pulse_start();
    run_to_done("frame_after_reset");

    // start in the done cycle chains a new frame
    rand_params();
    pulse_start();
    check_eq("chained_c_r", 32'(bus.it_c_r), 32'(x_start));
    run_to_done("frame_chained");

    // random frames with varying write-stall density
    for (int f = 0; f < 4; f++) begin
      wr_stall_pct = int'($urandom_range(0, 70));
      repeat (int'($urandom_range(0, 3))) step();
      rand_params();
      pulse_start();
      run_to_done("frame_random");
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
